conv_tree_deserializer_rx: RTL and testbench

- Receive-side stage directly downstream of conv_tree_serializer_16; samples its single-bit SERIAL_OUT stream on CLK rising edges.
- Recovers framed WIDTH-bit words and presents each on a one-entry valid/ready output buffer for the consumer.
- Flags framing errors and output overflow.
- Closes the loop in serializer/deserializer loopback benches and on-chip links.

---
 rtl/conv_tree_pkg.sv | 22 ++
 rtl/conv_tree_out_buf.sv | 33 +++
 rtl/conv_tree_deserializer_rx.sv | 95 +++++++++
 tb/tb_conv_tree_deserializer_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_tree_pkg.sv
// rtl/conv_tree_pkg.sv - shared width, receiver state type and bit-reversal helper for the conv-tree link
package conv_tree_pkg;

  localparam int CONV_TREE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } deser_state_t;

  // Reverse the low nbits of idx; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) r[5'(nbits - 1 - i)] = idx[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_tree_out_buf.sv
// rtl/conv_tree_out_buf.sv - one-entry valid/ready holding register with sticky overflow
module conv_tree_out_buf #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overflow
);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      // A same-edge consume frees the slot, so the new word replaces the old one.
      if (!valid || ready) begin
        data  <= load_data;
        valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_tree_deserializer_rx.sv
// rtl/conv_tree_deserializer_rx.sv - framed serial receiver for conv_tree_serializer_16 output
// Define CONV_TREE_BITREV_EN to store data bit k at PAR_OUT[bitrev(k)] instead of PAR_OUT[k].
module conv_tree_deserializer_rx
  import conv_tree_pkg::*;
#(
  parameter  int WIDTH = CONV_TREE_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SERIAL_IN,
  output logic [WIDTH-1:0] PAR_OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             FRAME_ERR,
  output logic             OVERFLOW,
  output logic             BUSY
);

  deser_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             load;
  logic [CNT_W-1:0] dest_idx;

`ifdef CONV_TREE_BITREV_EN
  assign dest_idx = CNT_W'(bitrev(32'(cnt_q), CNT_W));
`else
  assign dest_idx = cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    load        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (SERIAL_IN) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        shift_d[dest_idx] = SERIAL_IN;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        // A 1 here is a bad stop bit, never a new start bit.
        state_d = IDLE;
        if (SERIAL_IN) frame_err_d = 1'b1;
        else           load        = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign FRAME_ERR = frame_err_q;
  assign BUSY      = (state_q == DATA) || (state_q == STOP);

  conv_tree_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (load),
    .load_data(shift_q),
    .ready    (OUT_READY),
    .data     (PAR_OUT),
    .valid    (OUT_VALID),
    .overflow (OVERFLOW)
  );

endmodule

// File: tb/tb_conv_tree_deserializer_rx.sv
// tb/tb_conv_tree_deserializer_rx.sv - self-checking bench for conv_tree_deserializer_rx
module tb_conv_tree_deserializer_rx;

  localparam int W = 16;
  localparam int NMAX = 2048;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         SERIAL_IN = 1'b0;
  logic         OUT_READY = 1'b0;
  logic [W-1:0] PAR_OUT;
  logic         OUT_VALID;
  logic         FRAME_ERR;
  logic         OVERFLOW;
  logic         BUSY;

  int errors = 0;
  int checks = 0;

  conv_tree_deserializer_rx #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .SERIAL_IN(SERIAL_IN),
    .PAR_OUT  (PAR_OUT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .FRAME_ERR(FRAME_ERR),
    .OVERFLOW (OVERFLOW),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] word;
    logic        stop;
    logic        rdy;
    logic [15:0] exp_par;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  logic        ser_a[NMAX];
  logic        rdy_a[NMAX];
  logic        gv_a[NMAX];
  logic        ea_a[NMAX];
  logic        ba_a[NMAX];
  logic [15:0] gw_a[NMAX];

  // Expected word layout: data bit k lands at k, or at its 4-bit reversal.
  function automatic logic [15:0] rx_map(input logic [15:0] w);
    logic [15:0] r;
    r = w;
`ifdef CONV_TREE_BITREV_EN
    r = '0;
    for (int k = 0; k < 16; k++)
      r[4'((k % 2) * 8 + ((k / 2) % 2) * 4 + ((k / 4) % 2) * 2 + (k / 8) % 2)] = w[k];
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic s);
    SERIAL_IN = s;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] w, input logic stop, input logic rdy,
                            input logic rdy_stop);
    OUT_READY = rdy;
    step(1'b1);
    for (int k = 0; k < 16; k++) step(w[k]);
    OUT_READY = rdy_stop;
    step(stop);
  endtask

  task automatic do_reset();
    SERIAL_IN = 1'b0;
    OUT_READY = 1'b0;
    RESET = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    logic [15:0] prev;
    int n;
    int i;
    logic mv, mo;
    logic [15:0] md;

    // Reset state
    RESET = 1'b0;
    SERIAL_IN = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("rst_par", 32'(PAR_OUT), 0);
    chk("rst_valid", 32'(OUT_VALID), 0);
    chk("rst_err", 32'(FRAME_ERR), 0);
    chk("rst_ovf", 32'(OVERFLOW), 0);
    chk("rst_busy", 32'(BUSY), 0);
    RESET = 1'b1;
    for (int k = 0; k < 10; k++) step(1'b0);
    chk("idle_busy", 32'(BUSY), 0);
    chk("idle_valid", 32'(OUT_VALID), 0);

    // Latency: valid appears only after the stop edge and lasts one cycle with ready high
    OUT_READY = 1'b1;
    step(1'b1);
    chk("lat_busy_data", 32'(BUSY), 1);
    for (int k = 0; k < 16; k++) step(k[0] ? 1'b1 : 1'b0);
    chk("lat_busy_stop", 32'(BUSY), 1);
    chk("lat_valid_early", 32'(OUT_VALID), 0);
    step(1'b0);
    chk("lat_valid", 32'(OUT_VALID), 1);
    chk("lat_par", 32'(PAR_OUT), 32'(rx_map(16'hAAAA)));
    step(1'b0);
    chk("lat_valid_fall", 32'(OUT_VALID), 0);

    // Table-driven frames, consumer always ready
    vecs[0] = '{16'hC5AF, 1'b0, 1'b1, rx_map(16'hC5AF), 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 1'b1, 1'b1, rx_map(16'hC5AF), 1'b0, 1'b1};
    vecs[2] = '{16'hFFFF, 1'b0, 1'b1, rx_map(16'hFFFF), 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 1'b0, 1'b1, rx_map(16'h0000), 1'b1, 1'b0};
    vecs[4] = '{16'h8001, 1'b1, 1'b1, rx_map(16'h0000), 1'b0, 1'b1};
    vecs[5] = '{16'h5A5A, 1'b0, 1'b1, rx_map(16'h5A5A), 1'b1, 1'b0};
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].word, vecs[v].stop, vecs[v].rdy, vecs[v].rdy);
      chk($sformatf("tbl%0d_valid", v), 32'(OUT_VALID), 32'(vecs[v].exp_valid));
      chk($sformatf("tbl%0d_par", v), 32'(PAR_OUT), 32'(vecs[v].exp_par));
      chk($sformatf("tbl%0d_err", v), 32'(FRAME_ERR), 32'(vecs[v].exp_err));
      chk($sformatf("tbl%0d_busy", v), 32'(BUSY), 0);
      step(1'b0);
      chk($sformatf("tbl%0d_err_pulse", v), 32'(FRAME_ERR), 0);
      chk($sformatf("tbl%0d_valid_after", v), 32'(OUT_VALID), 0);
    end

    // Back-to-back frames into a full buffer
    do_reset();
    send_frame(16'h1234, 1'b0, 1'b0, 1'b0);
    chk("b2b_first_valid", 32'(OUT_VALID), 1);
    send_frame(16'hABCD, 1'b0, 1'b0, 1'b0);
    prev = rx_map(16'h1234);
    chk("b2b_par_hold", 32'(PAR_OUT), 32'(prev));
    chk("b2b_ovf", 32'(OVERFLOW), 1);
    chk("b2b_valid", 32'(OUT_VALID), 1);
    OUT_READY = 1'b1;
    step(1'b0);
    chk("b2b_valid_fall", 32'(OUT_VALID), 0);
    chk("b2b_par_kept", 32'(PAR_OUT), 32'(prev));
    chk("b2b_ovf_sticky", 32'(OVERFLOW), 1);

    // Ready on the same edge as the second stop bit
    do_reset();
    chk("reset_clears_ovf", 32'(OVERFLOW), 0);
    send_frame(16'h1234, 1'b0, 1'b0, 1'b0);
    send_frame(16'hABCD, 1'b0, 1'b0, 1'b1);
    chk("same_par", 32'(PAR_OUT), 32'(rx_map(16'hABCD)));
    chk("same_valid", 32'(OUT_VALID), 1);
    chk("same_ovf", 32'(OVERFLOW), 0);
    step(1'b0);
    chk("same_valid_fall", 32'(OUT_VALID), 0);

    // Asynchronous reset mid-frame
    OUT_READY = 1'b1;
    step(1'b1);
    for (int k = 0; k < 7; k++) step(1'b1);
    #2;
    RESET = 1'b0;
    #1;
    chk("async_busy", 32'(BUSY), 0);
    chk("async_par", 32'(PAR_OUT), 0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    send_frame(16'h00FF, 1'b0, 1'b1, 1'b1);
    chk("fresh_par", 32'(PAR_OUT), 32'(rx_map(16'h00FF)));
    chk("fresh_valid", 32'(OUT_VALID), 1);
    step(1'b0);

    // Randomized frames against an event-level reference model
    for (int e = 0; e < NMAX; e++) begin
      ser_a[e] = 1'b0; rdy_a[e] = 1'b0; gv_a[e] = 1'b0;
      ea_a[e] = 1'b0; ba_a[e] = 1'b0; gw_a[e] = '0;
    end
    n = 0;
    for (int f = 0; f < 50; f++) begin
      logic [15:0] w;
      logic stop;
      int gap, mode;
      gap = int'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 2));
      w = 16'($urandom);
      stop = ($urandom % 6) == 0;
      for (int g = 0; g < gap; g++) begin
        rdy_a[n] = ($urandom % 2) == 1;
        n++;
      end
      i = n;
      ser_a[i] = 1'b1;
      for (int k = 0; k < 16; k++) ser_a[i + 1 + k] = w[k];
      ser_a[i + 17] = stop;
      for (int k = 0; k <= 17; k++)
        rdy_a[i + k] = (mode == 2) ? 1'b1 : (mode == 0) ? 1'b0 : 1'(($urandom % 2) == 1);
      for (int k = 0; k <= 16; k++) ba_a[i + k] = 1'b1;
      if (stop) ea_a[i + 17] = 1'b1;
      else begin
        gv_a[i + 17] = 1'b1;
        gw_a[i + 17] = w;
      end
      n = i + 18;
    end
    for (int k = 0; k < 20; k++) begin
      rdy_a[n] = 1'b1;
      n++;
    end

    do_reset();
    mv = 1'b0; mo = 1'b0; md = '0;
    for (int e = 0; e < n; e++) begin
      SERIAL_IN = ser_a[e];
      OUT_READY = rdy_a[e];
      @(posedge CLK);
      #1;
      if (gv_a[e]) begin
        if (!mv || rdy_a[e]) begin
          md = rx_map(gw_a[e]);
          mv = 1'b1;
        end else mo = 1'b1;
      end else if (mv && rdy_a[e]) mv = 1'b0;
      chk($sformatf("rnd%0d_valid", e), 32'(OUT_VALID), 32'(mv));
      chk($sformatf("rnd%0d_par", e), 32'(PAR_OUT), 32'(md));
      chk($sformatf("rnd%0d_ovf", e), 32'(OVERFLOW), 32'(mo));
      chk($sformatf("rnd%0d_err", e), 32'(FRAME_ERR), 32'(ea_a[e]));
      chk($sformatf("rnd%0d_busy", e), 32'(BUSY), 32'(ba_a[e]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
